// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl
// AES-128 round-key sequencer. It expands the cipher key one round per
// accepted handshake, using an external combinational 4-byte S-box for
// SubWord. Round keys are presented on a valid/ready interface. A one-cycle
// done pulse follows the acceptance of round 10.
// Word packing: w0 is in bits [31:0] and w3 is in bits [127:96]. Byte 0 of a
// word is its most significant byte.
module key_schedule_ctrl #(
  parameter int KEY_LENGTH = 128  // only 128 (AES-128, Nk=4, Nr=10) is supported
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KEY_LENGTH-1:0] key,
  output logic                  busy,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [KEY_LENGTH-1:0] rk_data,
  output logic [3:0]            rk_round,
  output logic [31:0]           sub_word_in,
  input  logic [31:0]           sub_word_out,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  state_e                  state_q, state_d;
  logic [KEY_LENGTH-1:0]   rk_data_q, rk_data_d;
  logic [3:0]              rk_round_q, rk_round_d;
  logic                    rk_valid_q, rk_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    handshake;
  logic [3:0]              rcon_idx;
  logic [31:0]             t_word;
  logic [31:0]             n0, n1, n2, n3;
  logic [KEY_LENGTH-1:0]   next_key;

  // Round constant for round idx (1..10); anything else maps to zero.
  function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // RotWord: cyclic left rotation by one byte, where byte 0 is [31:24].
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // The S-box always sees the rotated last word of the current round key.
  assign sub_word_in = rot_word(rk_data_q[127:96]);

  // Next round key, built from the current words and the external SubWord result.
  always_comb begin
    rcon_idx = rk_round_q + 4'd1;
    t_word   = sub_word_out ^ {rcon_lookup(rcon_idx), 24'h000000};
    n0       = rk_data_q[31:0]   ^ t_word;
    n1       = rk_data_q[63:32]  ^ n0;
    n2       = rk_data_q[95:64]  ^ n1;
    n3       = rk_data_q[127:96] ^ n2;
    next_key = {n3, n2, n1, n0};
  end

  // Next-state logic: accept a job, advance one round per handshake, pulse done.
  always_comb begin
    state_d    = state_q;
    rk_data_d  = rk_data_q;
    rk_round_d = rk_round_q;
    // rk_valid_q is high only in EXPAND, so ready has no effect while idle.
    handshake  = rk_valid_q & rk_ready;

    case (state_q)
      IDLE: begin
        if (start) begin
          rk_data_d  = key;
          rk_round_d = 4'd0;
          state_d    = EXPAND;
        end else begin
          state_d    = IDLE;
        end
      end
      EXPAND: begin
        if (handshake) begin
          if (rk_round_q == LAST_ROUND) begin
            // Hold round 10 on the bus; the counter never wraps by itself.
            state_d = FINISH;
          end else begin
            rk_data_d  = next_key;
            rk_round_d = rk_round_q + 4'd1;
          end
        end else begin
          state_d = EXPAND;
        end
      end
      FINISH: begin
        // start is ignored here; the next job begins from IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered from the next state, so they line up with it.
    rk_valid_d = (state_d == EXPAND);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FINISH);
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rk_data_q  <= '0;
      rk_round_q <= 4'd0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_data_q  <= rk_data_d;
      rk_round_q <= rk_round_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rk_data  = rk_data_q;
  assign rk_round = rk_round_q;
  assign rk_valid = rk_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
